apb_manager: RTL and testbench

APB manager (initiator) for the 8-bit, 3-bit-address APB bus used by the UART receiver subordinate. It accepts read and write commands on a valid/ready port and buffers them in a small command FIFO. Each command becomes one fixed-length SETUP/ACCESS APB transfer, and the block returns one in-order response per command carrying read data and the subordinate error flag. It sits on the host/test side of the bus, driving psel/penable/pwrite/paddr/pwdata into the subordinate and sampling prdata/psaterr.

---
 rtl/apb_manager_if.sv | 35 +++
 rtl/apb_manager.sv | 126 ++++++++++++
 tb/tb_apb_manager.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_manager_if.sv
// Command/response port and APB bus of the APB manager, bundled together.
// The master modport is the manager's view; the slave modport is the
// view of whatever sits on the other side (host and subordinate).
interface apb_manager_if;
  // command port
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_wdata;
  // response port
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  // APB bus
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [2:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       psaterr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, psaterr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, psaterr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_manager.sv
// APB manager: buffers read/write commands in a small FIFO, runs each one
// as a fixed two-cycle SETUP/ACCESS transfer, and returns one in-order
// response per command with the read data and subordinate error flag.
module apb_manager #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          n_rst,
  apb_manager_if.master bus,
  output logic          busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  typedef struct packed {
    logic       write;
    logic [2:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  cmd_t          mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  cmd_t          head;
  logic          push, pop;

  state_t        state, next_state;
  logic          next_psel, next_penable;

  assign bus.cmd_ready = (count != FULL);
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign head          = mem[rd_ptr];
  assign busy          = (count != '0) || (state != IDLE);

  // Command storage: write the incoming command at the tail.
  // NOTE: the storage array has no reset; emptiness is tracked by the
  // pointers and count alone, so clearing the data would buy nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Transfer sequencing: next state, pop strobe and next APB phase outputs.
  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    next_state   = state;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          next_state = SETUP;
          pop        = 1'b1;
        end
      end
      SETUP:  next_state = ACCESS;
      ACCESS: begin
        if (count != '0) begin
          next_state = SETUP;
          pop        = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    next_psel    = (next_state != IDLE);
    next_penable = (next_state == ACCESS);
  end

  // State, APB outputs and response outputs, all registered.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      bus.psel      <= 1'b0;
      bus.penable   <= 1'b0;
      bus.pwrite    <= 1'b0;
      bus.paddr     <= '0;
      bus.pwdata    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      state       <= next_state;
      bus.psel    <= next_psel;
      bus.penable <= next_penable;
      if (pop) begin
        bus.pwrite <= head.write;
        bus.paddr  <= head.addr;
        bus.pwdata <= head.wdata;
      end
      bus.rsp_valid <= (state == ACCESS);
      if (state == ACCESS) begin
        bus.rsp_err   <= bus.psaterr;
        bus.rsp_rdata <= bus.pwrite ? 8'h00 : bus.prdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_manager.sv
// Directed bench for apb_manager with a small register-file subordinate.
module tb_apb_manager;

  logic clk;
  logic n_rst;
  logic busy;

  apb_manager_if bus ();

  apb_manager #(.FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.master),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Subordinate model: 8 registers, address 0 read-only (write -> error).
  // prdata/psaterr are registered during SETUP; writes commit at end of ACCESS.
  logic [7:0] regs [8];
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
      regs[0] <= 8'h5A;
      regs[2] <= 8'h0A;
      regs[4] <= 8'h08;
      bus.prdata  <= 8'h00;
      bus.psaterr <= 1'b0;
    end else begin
      if (bus.psel && !bus.penable) begin
        bus.prdata  <= regs[bus.paddr];
        bus.psaterr <= bus.pwrite && (bus.paddr == 3'd0);
      end
      if (bus.psel && bus.penable && bus.pwrite && (bus.paddr != 3'd0))
        regs[bus.paddr] <= bus.pwdata;
    end
  end

  // Monitor: cycle counter, bus activity counts and captured responses.
  int unsigned cyc = 0;
  int unsigned psel_hi = 0;
  int unsigned pen_hi = 0;
  logic [7:0]  rq_data [$];
  logic        rq_err [$];
  int unsigned rq_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.psel)    psel_hi <= psel_hi + 1;
    if (bus.penable) pen_hi  <= pen_hi + 1;
    if (bus.rsp_valid) begin
      rq_data.push_back(bus.rsp_rdata);
      rq_err.push_back(bus.rsp_err);
      rq_cyc.push_back(cyc);
    end
  end

  int total = 0;
  int passed = 0;
  int stalls = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic push(input logic w, input logic [2:0] a, input logic [7:0] d);
    logic rdy;
    logic ok;
    ok = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    for (int t = 0; t < 50; t++) begin
      rdy = bus.cmd_ready;
      tick();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
      stalls++;
    end
    bus.cmd_valid = 1'b0;
    if (!ok) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input int target);
    for (int t = 0; t < 100 && rq_data.size() < target; t++) tick();
    if (rq_data.size() < target) chk("rsp_timeout", rq_data.size(), target);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 100 && busy; t++) tick();
    tick();
  endtask

  int b;
  int unsigned ps0, pe0, st0;
  logic [7:0] exp_d [8];
  logic       exp_e [8];

  initial begin
    n_rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 3'd0;
    bus.cmd_wdata = 8'h00;
    #3 n_rst = 1'b0;

    // Reset with random command inputs
    for (int i = 0; i < 4; i++) begin
      bus.cmd_valid = 1'($urandom);
      bus.cmd_write = 1'($urandom);
      bus.cmd_addr  = 3'($urandom);
      bus.cmd_wdata = 8'($urandom);
      tick();
    end
    chk("rst_psel", bus.psel, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_pwrite", bus.pwrite, 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_pwdata", bus.pwdata, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b0;
    n_rst = 1'b1;
    ps0 = psel_hi;
    repeat (5) tick();
    chk("idle_no_psel", psel_hi - ps0, 0);
    chk("idle_busy", busy, 0);

    // Single write addr 2 <- 0x34, cycle-exact latency
    b = rq_data.size();
    push(1'b1, 3'd2, 8'h34);
    chk("wr_e0_psel", bus.psel, 0);
    chk("wr_e0_busy", busy, 1);
    tick();
    chk("wr_e1_psel", bus.psel, 1);
    chk("wr_e1_penable", bus.penable, 0);
    chk("wr_e1_pwrite", bus.pwrite, 1);
    chk("wr_e1_paddr", bus.paddr, 2);
    chk("wr_e1_pwdata", bus.pwdata, 8'h34);
    tick();
    chk("wr_e2_psel", bus.psel, 1);
    chk("wr_e2_penable", bus.penable, 1);
    chk("wr_e2_pwdata", bus.pwdata, 8'h34);
    tick();
    chk("wr_e3_rsp_valid", bus.rsp_valid, 1);
    chk("wr_e3_rsp_err", bus.rsp_err, 0);
    chk("wr_e3_rsp_rdata", bus.rsp_rdata, 0);
    chk("wr_e3_psel", bus.psel, 0);
    chk("wr_e3_pwrite_hold", bus.pwrite, 1);
    tick();
    chk("wr_e4_rsp_valid", bus.rsp_valid, 0);
    chk("wr_e4_busy", busy, 0);
    chk("wr_sub_reg2", regs[2], 8'h34);
    chk("wr_rsp_count", rq_data.size() - b, 1);

    // Read addr 4 (reset value 0x08), then erroring write to read-only addr 0
    b = rq_data.size();
    push(1'b0, 3'd4, 8'hEE);
    wait_rsp(b + 1);
    chk("rd4_rdata", rq_data[b], 8'h08);
    chk("rd4_err", rq_err[b], 0);
    repeat (3) tick();
    chk("rd4_rdata_hold", bus.rsp_rdata, 8'h08);
    push(1'b1, 3'd0, 8'hFF);
    wait_rsp(b + 2);
    chk("wr0_err", rq_err[b+1], 1);
    chk("wr0_rdata", rq_data[b+1], 0);
    repeat (2) tick();
    chk("wr0_err_hold", bus.rsp_err, 1);
    wait_idle();

    // Eight back-to-back commands: fills the FIFO, one stalled cycle
    exp_d = '{8'h08, 8'h00, 8'h11, 8'h5A, 8'h00, 8'h22, 8'h00, 8'h00};
    exp_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    b   = rq_data.size();
    ps0 = psel_hi;
    pe0 = pen_hi;
    st0 = stalls;
    push(1'b0, 3'd4, 8'h00);
    push(1'b1, 3'd5, 8'h11);
    push(1'b0, 3'd5, 8'h00);
    push(1'b0, 3'd0, 8'h00);
    push(1'b1, 3'd6, 8'h22);
    push(1'b0, 3'd6, 8'h00);
    chk("b2b_full_ready", bus.cmd_ready, 1);
    push(1'b1, 3'd0, 8'h77);
    chk("b2b_full_ready_low", bus.cmd_ready, 0);
    push(1'b0, 3'd7, 8'h00);
    chk("b2b_stalls", stalls - st0, 1);
    wait_rsp(b + 8);
    wait_idle();
    chk("b2b_rsp_count", rq_data.size() - b, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b_rdata%0d", i), rq_data[b+i], exp_d[i]);
      chk($sformatf("b2b_err%0d", i), rq_err[b+i], exp_e[i]);
    end
    for (int i = 1; i < 8; i++)
      chk($sformatf("b2b_gap%0d", i), rq_cyc[b+i] - rq_cyc[b+i-1], 2);
    chk("b2b_psel_cycles", psel_hi - ps0, 16);
    chk("b2b_penable_cycles", pen_hi - pe0, 8);

    // Write/read-back and earlier write still visible
    b = rq_data.size();
    push(1'b1, 3'd3, 8'h01);
    push(1'b0, 3'd3, 8'h00);
    push(1'b0, 3'd2, 8'h00);
    wait_rsp(b + 3);
    chk("rb_wr3_rdata", rq_data[b], 0);
    chk("rb_rd3_rdata", rq_data[b+1], 8'h01);
    chk("rb_rd2_rdata", rq_data[b+2], 8'h34);
    wait_idle();

    // Reset during ACCESS with two commands queued
    b = rq_data.size();
    push(1'b0, 3'd4, 8'h00);
    push(1'b0, 3'd2, 8'h00);
    push(1'b0, 3'd3, 8'h00);
    chk("mid_in_access", bus.penable, 1);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_psel", bus.psel, 0);
    chk("mid_rst_penable", bus.penable, 0);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cmd_ready", bus.cmd_ready, 1);
    tick();
    tick();
    n_rst = 1'b1;
    ps0 = psel_hi;
    repeat (10) tick();
    chk("mid_no_rsp", rq_data.size() - b, 0);
    chk("mid_no_psel", psel_hi - ps0, 0);
    chk("mid_busy", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
